// File: rtl/stopwatch_pkg.sv
// Shared constants and types for the stopwatch display path: digit count,
// active-low 7-segment patterns {g,f,e,d,c,b,a} and the BCD digit type.
package stopwatch_pkg;

  localparam int NUM_DIGITS = 6;

  localparam logic [6:0] SEG_OFF  = 7'h7F;
  localparam logic [6:0] SEG_DASH = 7'b0111111;

  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  typedef logic [3:0] digit_t;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to active-low 7-segment decoder; codes above 9 show a dash.
module bcd_to_seg7
  import stopwatch_pkg::*;
(
  input  digit_t     i_digit,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_DASH;
    if (i_digit <= 4'd9) begin
      o_seg = SEG_DIGIT[i_digit];
    end
  end

endmodule

// File: rtl/stopwatch_display_scan.sv
// Six-digit multiplexed 7-segment scanner with blanking gap and lap-hold freeze.
// Optional leading-zero suppression on the top three digits: LEADING_ZERO_BLANK_EN.
module stopwatch_display_scan
  import stopwatch_pkg::*;
#(
  parameter int          SCAN_DIV = 50_000,
  parameter logic [5:0]  DP_MASK  = 6'b010100
)
(
  input  logic       clk,
  input  logic       reset_n,
  input  digit_t     d,
  input  digit_t     e,
  input  digit_t     f,
  input  digit_t     g,
  input  digit_t     h,
  input  digit_t     i,
  input  logic       lap,
  output logic [5:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       hold
);

  localparam int               CNT_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [2:0]       IDX_LAST = 3'(NUM_DIGITS - 1);

  localparam logic [0:0] ST_LIVE = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_idx;
  logic             r_lapQ;
  logic [0:0]       r_state;
  logic [23:0]      r_snap;

  logic        w_tick;
  logic        w_lapRise;
  logic        w_blank;
  logic [23:0] w_live;
  logic [23:0] w_src;
  digit_t      w_digit;
  logic [6:0]  w_seg;

  assign w_tick    = (r_cnt == CNT_LAST);
  assign w_lapRise = lap & ~r_lapQ;
  assign w_live    = {i, h, g, f, e, d};
  assign w_src     = (r_state == ST_HOLD) ? r_snap : w_live;
  assign w_digit   = w_src[{r_idx, 2'b00} +: 4];
  assign hold      = (r_state == ST_HOLD);

`ifdef LEADING_ZERO_BLANK_EN
  always_comb begin
    w_blank = 1'b0;
    case (r_idx)
      3'd5:    w_blank = (w_src[23:20] == 4'd0);
      3'd4:    w_blank = (w_src[23:16] == 8'd0);
      3'd3:    w_blank = (w_src[23:12] == 12'd0);
      default: w_blank = 1'b0;
    endcase
  end
`else
  assign w_blank = 1'b0;
`endif

  bcd_to_seg7 u_dec (
    .i_digit (w_digit),
    .o_seg   (w_seg)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else if (w_tick) begin
      r_cnt <= '0;
      r_idx <= (r_idx == IDX_LAST) ? 3'd0 : r_idx + 3'd1;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Snapshot is only captured when entering HOLD, so the timer keeps running underneath
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_lapQ  <= 1'b0;
      r_state <= ST_LIVE;
      r_snap  <= '0;
    end else begin
      r_lapQ <= lap;
      if (w_lapRise) begin
        if (r_state == ST_LIVE) begin
          r_snap  <= w_live;
          r_state <= ST_HOLD;
        end else begin
          r_state <= ST_LIVE;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      an  <= 6'b111111;
      seg <= SEG_OFF;
      dp  <= 1'b1;
    end else if (w_tick || w_blank) begin
      an  <= 6'b111111;
      seg <= SEG_OFF;
      dp  <= 1'b1;
    end else begin
      an  <= ~(6'b000001 << r_idx);
      seg <= w_seg;
      dp  <= ~DP_MASK[r_idx];
    end
  end

endmodule

// File: tb/tb_stopwatch_display_scan.sv
// Self-checking bench for stopwatch_display_scan with SCAN_DIV=4; expected pin
// values come from a slot-position model and flow through a scoreboard queue.
module tb_stopwatch_display_scan;

  localparam int         SD  = 4;
  localparam logic [5:0] DPM = 6'b010100;

  typedef struct {
    logic [5:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       hold;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       lap = 1'b0;
  logic [3:0] dig [6];
  logic [5:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       hold;

  int         vectors = 0;
  int         miscompares = 0;
  exp_t       sbq [$];

  int         k;
  bit         mHold;
  bit         mLapQ;
  logic [3:0] mSnap [6];

  always #5 clk = ~clk;

  stopwatch_display_scan #(.SCAN_DIV(SD), .DP_MASK(DPM)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (dig[0]),
    .e       (dig[1]),
    .f       (dig[2]),
    .g       (dig[3]),
    .h       (dig[4]),
    .i       (dig[5]),
    .lap     (lap),
    .an      (an),
    .seg     (seg),
    .dp      (dp),
    .hold    (hold)
  );

  function automatic logic [6:0] refSeg(input logic [3:0] v);
    case (v)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return 7'b0111111;
    endcase
  endfunction

  task automatic modelReset();
    k = 0;
    mHold = 1'b0;
    mLapQ = 1'b0;
    for (int j = 0; j < 6; j++) mSnap[j] = 4'd0;
  endtask

  // Predict the pins after the next rising edge, queue it, then take that edge.
  task automatic advance();
    exp_t       ex;
    int         slot;
    int         pos;
    logic [3:0] src [6];
    bit         off;
    bit         rise;
    bit         newHold;
    slot = (k / SD) % 6;
    pos  = k % SD;
    for (int j = 0; j < 6; j++) src[j] = mHold ? mSnap[j] : dig[j];
    off = (pos == SD - 1);
`ifdef LEADING_ZERO_BLANK_EN
    if (slot == 5 && src[5] == 0) off = 1'b1;
    if (slot == 4 && src[5] == 0 && src[4] == 0) off = 1'b1;
    if (slot == 3 && src[5] == 0 && src[4] == 0 && src[3] == 0) off = 1'b1;
`endif
    if (off) begin
      ex.an  = 6'b111111;
      ex.seg = 7'h7F;
      ex.dp  = 1'b1;
    end else begin
      ex.an  = 6'b111111 & ~(6'b000001 << slot);
      ex.seg = refSeg(src[slot]);
      ex.dp  = ~DPM[slot];
    end
    rise    = lap && !mLapQ;
    newHold = rise ? !mHold : mHold;
    ex.hold = newHold;
    sbq.push_back(ex);
    @(posedge clk);
    if (rise && !mHold) for (int j = 0; j < 6; j++) mSnap[j] = dig[j];
    mHold = newHold;
    mLapQ = lap;
    k++;
    #1;
  endtask

  task automatic setDigits(input logic [3:0] v0, v1, v2, v3, v4, v5);
    dig[0] = v0; dig[1] = v1; dig[2] = v2;
    dig[3] = v3; dig[4] = v4; dig[5] = v5;
  endtask

  task automatic test_reset();
    exp_t ex;
    #12;
    vectors++;
    if (an !== 6'b111111 || seg !== 7'h7F || dp !== 1'b1 || hold !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_initial got an=%b seg=%h dp=%b hold=%b want 111111/7f/1/0", an, seg, dp, hold);
    end
    @(negedge clk);
    reset_n = 1'b1;
    modelReset();
    setDigits(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6);
    for (int n = 0; n < 9; n++) begin
      lap = (n == 2);
      advance();
      ex = sbq.pop_front();
      vectors++;
      if (an !== ex.an || seg !== ex.seg || dp !== ex.dp || hold !== ex.hold) begin
        miscompares++;
        $display("[TB] FAIL reset_prerun k=%0d got an=%b seg=%h dp=%b hold=%b want an=%b seg=%h dp=%b hold=%b",
                 k, an, seg, dp, hold, ex.an, ex.seg, ex.dp, ex.hold);
      end
    end
    lap = 1'b0;
    #3;
    reset_n = 1'b0;
    #1;
    vectors++;
    if (an !== 6'b111111 || seg !== 7'h7F || dp !== 1'b1 || hold !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_async got an=%b seg=%h dp=%b hold=%b want 111111/7f/1/0", an, seg, dp, hold);
    end
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (an !== 6'b111111 || seg !== 7'h7F || dp !== 1'b1 || hold !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_held got an=%b seg=%h dp=%b hold=%b want 111111/7f/1/0", an, seg, dp, hold);
    end
    @(negedge clk);
    reset_n = 1'b1;
    modelReset();
  endtask

  task automatic test_scan();
    exp_t ex;
    setDigits(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6);
    for (int n = 0; n < 48; n++) begin
      advance();
      ex = sbq.pop_front();
      vectors++;
      if (an !== ex.an || seg !== ex.seg || dp !== ex.dp || hold !== ex.hold) begin
        miscompares++;
        $display("[TB] FAIL scan k=%0d got an=%b seg=%h dp=%b hold=%b want an=%b seg=%h dp=%b hold=%b",
                 k, an, seg, dp, hold, ex.an, ex.seg, ex.dp, ex.hold);
      end
    end
  endtask

  task automatic test_lap();
    exp_t ex;
    setDigits(4'd3, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0);
    for (int n = 0; n < 60; n++) begin
      lap = (n == 1 || n == 30);
      if (n == 3) dig[0] = 4'd7;
      advance();
      ex = sbq.pop_front();
      vectors++;
      if (an !== ex.an || seg !== ex.seg || dp !== ex.dp || hold !== ex.hold) begin
        miscompares++;
        $display("[TB] FAIL lap k=%0d got an=%b seg=%h dp=%b hold=%b want an=%b seg=%h dp=%b hold=%b",
                 k, an, seg, dp, hold, ex.an, ex.seg, ex.dp, ex.hold);
      end
    end
    lap = 1'b0;
  endtask

  task automatic test_lap_level();
    exp_t ex;
    setDigits(4'd9, 4'd8, 4'd0, 4'd0, 4'd0, 4'd0);
    for (int n = 0; n < 30; n++) begin
      lap = (n >= 2 && n < 12);
      if (n == 14) dig[0] = 4'd1;
      advance();
      ex = sbq.pop_front();
      vectors++;
      if (an !== ex.an || seg !== ex.seg || dp !== ex.dp || hold !== ex.hold) begin
        miscompares++;
        $display("[TB] FAIL lap_level k=%0d got an=%b seg=%h dp=%b hold=%b want an=%b seg=%h dp=%b hold=%b",
                 k, an, seg, dp, hold, ex.an, ex.seg, ex.dp, ex.hold);
      end
    end
    lap = 1'b0;
    vectors++;
    if (hold !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL lap_level_final got hold=%b want 1", hold);
    end
    lap = 1'b1;
    advance();
    ex = sbq.pop_front();
    lap = 1'b0;
    vectors++;
    if (hold !== ex.hold || an !== ex.an || seg !== ex.seg) begin
      miscompares++;
      $display("[TB] FAIL lap_release got an=%b seg=%h hold=%b want an=%b seg=%h hold=%b",
               an, seg, hold, ex.an, ex.seg, ex.hold);
    end
  endtask

  task automatic test_invalid_bcd();
    exp_t ex;
    setDigits(4'hA, 4'hF, 4'd2, 4'd3, 4'd4, 4'd5);
    for (int n = 0; n < 24; n++) begin
      advance();
      ex = sbq.pop_front();
      vectors++;
      if (an !== ex.an || seg !== ex.seg || dp !== ex.dp || hold !== ex.hold) begin
        miscompares++;
        $display("[TB] FAIL invalid_bcd k=%0d got an=%b seg=%h dp=%b hold=%b want an=%b seg=%h dp=%b hold=%b",
                 k, an, seg, dp, hold, ex.an, ex.seg, ex.dp, ex.hold);
      end
    end
  endtask

  task automatic test_leading_zero();
    exp_t ex;
    setDigits(4'd1, 4'd2, 4'd3, 4'd5, 4'd0, 4'd0);
    for (int n = 0; n < 24; n++) begin
      advance();
      ex = sbq.pop_front();
      vectors++;
      if (an !== ex.an || seg !== ex.seg || dp !== ex.dp || hold !== ex.hold) begin
        miscompares++;
        $display("[TB] FAIL leading_zero k=%0d got an=%b seg=%h dp=%b hold=%b want an=%b seg=%h dp=%b hold=%b",
                 k, an, seg, dp, hold, ex.an, ex.seg, ex.dp, ex.hold);
      end
    end
  endtask

  initial begin
    for (int j = 0; j < 6; j++) dig[j] = 4'd0;
    modelReset();
    test_reset();
    test_scan();
    test_lap();
    test_lap_level();
    test_invalid_bcd();
    test_leading_zero();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
